// File: rtl/j11bus_pkg.sv
// Shared constants, FSM state type and helpers for the DCJ11 bus controller.
package j11bus_pkg;

    localparam logic [15:0] POWERUP   = 16'o3;
    localparam logic [7:0]  GP_PWR    = 8'o0;
    localparam logic [7:0]  GP_RSTON  = 8'o14;
    localparam logic [7:0]  GP_ODTON  = 8'o34;
    localparam logic [7:0]  GP_RSTOFF = 8'o214;
    localparam logic [7:0]  GP_ODTOFF = 8'o234;

    typedef enum logic {IDLE, WAIT} state_t;

    function automatic logic [1:0] lvl_of(input logic [3:0] oh);
        logic [1:0] l;
        l = 2'd0;
        for (int k = 0; k < 4; k++)
            if (oh[k]) l = 2'(k);
        return l;
    endfunction

endpackage

// File: rtl/j11irqarb.sv
// Interrupt pending bits, per-BR-level request OR and IACK vector selection.
import j11bus_pkg::*;

module j11irqarb #(
    parameter int                  NIRQ    = 4,
    parameter logic [NIRQ*16-1:0]  VECTORS = {16'o100, 16'o160, 16'o64, 16'o60},
    parameter logic [NIRQ*2-1:0]   LEVELS  = {2'd2, 2'd1, 2'd0, 2'd0}
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [NIRQ-1:0] irq,
    input  logic            ack,
    input  logic [3:0]      acklvl,
    output logic [3:0]      j11irq,
    output logic [15:0]     vector,
    output logic            hit
);

    logic [NIRQ-1:0] pending;
    logic [NIRQ-1:0] clr;
    logic [3:0]      lvlor;
    logic [1:0]      lvl;
    logic            found;

    // Lowest-index pending channel on the acked level wins.
    always_comb begin
        lvl    = lvl_of(acklvl);
        found  = 1'b0;
        clr    = '0;
        vector = '0;
        for (int i = 0; i < NIRQ; i++) begin
            if (!found && pending[i] && LEVELS[2*i +: 2] == lvl) begin
                found  = 1'b1;
                clr[i] = 1'b1;
                vector = VECTORS[16*i +: 16];
            end
        end
        hit = found & $onehot(acklvl);
    end

    always_comb begin
        lvlor = '0;
        for (int i = 0; i < NIRQ; i++)
            lvlor[LEVELS[2*i +: 2]] = lvlor[LEVELS[2*i +: 2]] | pending[i];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending <= '0;
            j11irq  <= '0;
        end else begin
            // A new request in the same cycle as its acknowledge stays pending.
            pending <= (pending & ~((ack && hit) ? clr : '0)) | irq;
            j11irq  <= lvlor;
        end
    end

endmodule

// File: rtl/j11busctl.sv
// DCJ11 bus controller: GP registers, IACK cycles and memory requests with
// a bus-error timeout.
import j11bus_pkg::*;

module j11busctl #(
    parameter int                  NIRQ    = 4,
    parameter logic [NIRQ*16-1:0]  VECTORS = {16'o100, 16'o160, 16'o64, 16'o60},
    parameter logic [NIRQ*2-1:0]   LEVELS  = {2'd2, 2'd1, 2'd0, 2'd0},
    parameter int                  TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            busreq,
    input  logic            buswr,
    input  logic            busgp,
    input  logic            busirq,
    input  logic [21:0]     busaddr,
    input  logic [15:0]     buswdata,
    input  logic [1:0]      buswstrb,
    output logic            busack,
    output logic            buserr,
    output logic [15:0]     busrdata,
    output logic            busrst,
    output logic            odt,
    output logic            memreq,
    output logic            memwr,
    output logic [21:0]     memaddr,
    output logic [15:0]     memwdata,
    output logic [1:0]      memwstrb,
    input  logic            memack,
    input  logic [15:0]     memrdata,
    input  logic            memerr,
    input  logic [NIRQ-1:0] irq,
    output logic [3:0]      j11irq,
    output logic            j11init,
    output logic            j11halt,
    input  logic            regreq,
    input  logic [31:0]     regwdata,
    output logic            regack
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] cnt;
    logic        iack;
    logic        hit;
    logic [15:0] vector;
    logic        unused_regw;

    assign memwr       = buswr;
    assign memaddr     = busaddr;
    assign memwdata    = buswdata;
    assign memwstrb    = buswstrb;
    assign unused_regw = ^regwdata[31:2];

    // Requests arriving while a memory cycle is outstanding are dropped.
    assign iack = busreq & busirq & ~busgp & (state == IDLE);

    j11irqarb #(
        .NIRQ    (NIRQ),
        .VECTORS (VECTORS),
        .LEVELS  (LEVELS)
    ) u_arb (
        .clk    (clk),
        .rstn   (rstn),
        .irq    (irq),
        .ack    (iack),
        .acklvl (busaddr[3:0]),
        .j11irq (j11irq),
        .vector (vector),
        .hit    (hit)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            cnt      <= '0;
            busack   <= 1'b0;
            buserr   <= 1'b0;
            busrdata <= '0;
            busrst   <= 1'b1;
            odt      <= 1'b0;
            memreq   <= 1'b0;
            regack   <= 1'b0;
            j11init  <= 1'b0;
            j11halt  <= 1'b0;
        end else begin
            busack <= 1'b0;
            memreq <= 1'b0;
            regack <= regreq;
            if (regreq) begin
                j11init <= regwdata[0];
                j11halt <= regwdata[1];
            end
            unique case (state)
                IDLE: begin
                    if (busreq) begin
                        if (busgp) begin
                            busack   <= 1'b1;
                            buserr   <= 1'b0;
                            busrdata <= (!buswr && busaddr[7:0] == GP_PWR) ?
                                        POWERUP : '0;
                            if (buswr) begin
                                case (busaddr[7:0])
                                    GP_RSTON:  busrst <= 1'b1;
                                    GP_RSTOFF: busrst <= 1'b0;
                                    GP_ODTON:  odt    <= 1'b1;
                                    GP_ODTOFF: odt    <= 1'b0;
                                    default: ;
                                endcase
                            end
                        end else if (busirq) begin
                            busack   <= 1'b1;
                            buserr   <= ~hit;
                            busrdata <= hit ? vector : '0;
                        end else begin
                            state  <= WAIT;
                            memreq <= 1'b1;
                            cnt    <= '0;
                        end
                    end
                end
                WAIT: begin
                    if (memack) begin
                        busack   <= 1'b1;
                        busrdata <= memrdata;
                        buserr   <= memerr;
                        state    <= IDLE;
                    end else if (cnt == TMO_LAST) begin
                        busack   <= 1'b1;
                        busrdata <= '0;
                        buserr   <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
            endcase
        end
    end

endmodule
